// File: rtl/riscv_v_pkg.sv
// riscv_v_pkg: shared types for the vector logic/shift/reduction pipe
// Provides the op encoding, element-size encoding, FSM state type and op class helper.
package riscv_v_pkg;
  typedef enum logic [3:0] {
    OP_AND    = 4'd0,
    OP_OR     = 4'd1,
    OP_XOR    = 4'd2,
    OP_SLL    = 4'd3,
    OP_SRL    = 4'd4,
    OP_SRA    = 4'd5,
    OP_REDAND = 4'd6,
    OP_REDOR  = 4'd7,
    OP_REDXOR = 4'd8
  } riscv_v_logic_op_e;
  typedef enum logic [1:0] {
    OSZ_8  = 2'd0,
    OSZ_16 = 2'd1,
    OSZ_32 = 2'd2,
    OSZ_64 = 2'd3
  } riscv_v_osize_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FOLD = 2'd1,
    ST_OUT  = 2'd2
  } riscv_v_logic_state_e;
  localparam int OSIZE_N = 4;
  function automatic logic is_red(input logic [3:0] op);
    return op == OP_REDAND || op == OP_REDOR || op == OP_REDXOR;
  endfunction
endpackage

// File: rtl/riscv_v_logic_fold.sv
// riscv_v_logic_fold: one combinational reduction fold step
// Ports: op (reduction kind), osize (element size), stage (folds remaining, >=1),
//        din (current partial vector), dout (upper half of the active region
//        combined into the lower half, everything above that half cleared).
module riscv_v_logic_fold
  import riscv_v_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CW = $clog2(DATA_W / 8)
) (
  input  logic [3:0]        op,
  input  logic [1:0]        osize,
  input  logic [CW-1:0]     stage,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  localparam int HW = $clog2(DATA_W) + 1;
  logic [HW-1:0] half;
  logic [DATA_W-1:0] hi, mask;
  // active region is esize << stage bits wide, so its half is esize << (stage-1)
  assign half = HW'(8) << (HW'(osize) + HW'(stage) - HW'(1));
  assign hi   = din >> half;
  assign mask = ~({DATA_W{1'b1}} << half);
  always_comb begin
    dout = op == OP_REDAND ? din & hi : op == OP_REDOR ? din | hi : din ^ hi;
    dout = dout & mask;
  end
endmodule

// File: rtl/riscv_v_logic_alu_pipe.sv
// riscv_v_logic_alu_pipe: vector bitwise/shift ALU with iterative reductions
// Ports: clk/rst (async active-high); in_valid/in_ready request handshake with
//        op, osize, srca (vs2), srcb (vs1 / shift amounts / reduction scalar),
//        src_bvalid; out_valid/out_ready result handshake with result and
//        result_bvalid. Elementwise ops take one cycle, reductions fold
//        log2(DATA_W/esize) times through riscv_v_logic_fold.
module riscv_v_logic_alu_pipe
  import riscv_v_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int BV_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [1:0]        osize,
  input  logic [DATA_W-1:0] srca,
  input  logic [DATA_W-1:0] srcb,
  input  logic [BV_W-1:0]   src_bvalid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [BV_W-1:0]   result_bvalid
);
  localparam int CW = $clog2(DATA_W / 8);
  riscv_v_logic_state_e state;
  riscv_v_osize_e osize_q;
  logic [3:0] op_q;
  logic [CW-1:0] cnt, k;
  logic [DATA_W-1:0] data, fold_out, ew_res;
  logic [BV_W-1:0] bv, ew_bv, bmask;
  logic [63:0] srcb_q, m64, sb, f64, c64;
  logic [6:0] ew_bits;
  logic [3:0] nb;
  logic [DATA_W-1:0] shf [OSIZE_N];
  logic [DATA_W-1:0] red [OSIZE_N];
  logic acc, red_op;
  for (genvar s = 0; s < OSIZE_N; s++) begin : g_sz
    localparam int EW = 8 << s;
    for (genvar e = 0; e < DATA_W / EW; e++) begin : g_el
      logic [EW-1:0] ea, sl, sr, ar;
      logic signed [EW-1:0] sa;
      logic [$clog2(EW)-1:0] amt;
      assign ea  = srca[e*EW+:EW];
      assign sa  = srca[e*EW+:EW];
      assign amt = srcb[e*EW+:$clog2(EW)];
      assign sl  = ea << amt;
      assign sr  = ea >> amt;
      assign ar  = sa >>> amt;
      assign shf[s][e*EW+:EW] = op == OP_SLL ? sl : op == OP_SRL ? sr : ar;
      // invalid elements enter the fold as the identity of the reduction
      assign red[s][e*EW+:EW] = src_bvalid[e*(EW/8)] ? ea : (op == OP_REDAND ? {EW{1'b1}} : {EW{1'b0}});
    end
  end
  riscv_v_logic_fold #(.DATA_W(DATA_W), .CW(CW)) u_fold (
    .op   (op_q),
    .osize(osize_q),
    .stage(cnt),
    .din  (data),
    .dout (fold_out)
  );
  assign in_ready      = state == ST_IDLE || (state == ST_OUT && out_ready);
  assign out_valid     = state == ST_OUT;
  assign result        = data;
  assign result_bvalid = bv;
  assign acc           = in_valid && in_ready;
  assign red_op        = is_red(op);
  assign k             = CW'(CW) - CW'(osize);
  always_comb begin
    ew_res = op == OP_AND ? srca & srcb
           : op == OP_OR  ? srca | srcb
           : op == OP_XOR ? srca ^ srcb
           : (op == OP_SLL || op == OP_SRL || op == OP_SRA) ? shf[osize]
           : '0;
    ew_bv = op > OP_SRA ? '0 : src_bvalid;
  end
  // last fold step: merge element 0 with the scalar from srcb element 0
  always_comb begin
    ew_bits = 7'd8 << osize_q;
    nb      = 4'd1 << osize_q;
    m64     = ~({64{1'b1}} << ew_bits);
    sb      = srcb_q & m64;
    f64     = fold_out[63:0];
    c64     = op_q == OP_REDAND ? f64 & sb : op_q == OP_REDOR ? f64 | sb : f64 ^ sb;
    bmask   = ~({BV_W{1'b1}} << nb);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      data    <= '0;
      bv      <= '0;
      op_q    <= '0;
      osize_q <= OSZ_8;
      srcb_q  <= '0;
    end else if (acc) begin
      op_q    <= op;
      osize_q <= riscv_v_osize_e'(osize);
      srcb_q  <= srcb[63:0];
      state   <= red_op ? ST_FOLD : ST_OUT;
      cnt     <= red_op ? k : '0;
      data    <= red_op ? red[osize] : ew_res;
      bv      <= red_op ? '0 : ew_bv;
    end else if (state == ST_FOLD) begin
      cnt   <= cnt - 1'b1;
      data  <= cnt == CW'(1) ? DATA_W'(c64) : fold_out;
      bv    <= cnt == CW'(1) ? bmask : bv;
      state <= cnt == CW'(1) ? ST_OUT : ST_FOLD;
    end else if (state == ST_OUT && out_ready) begin
      state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_riscv_v_logic_alu_pipe.sv
// tb_riscv_v_logic_alu_pipe: scoreboard bench with element-level reference model
module tb_riscv_v_logic_alu_pipe;
  localparam int DW = 128;
  localparam int BW = 16;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [3:0] op = 0;
  logic [1:0] osize = 0;
  logic [DW-1:0] srca = 0, srcb = 0, result;
  logic [BW-1:0] src_bvalid = 0, result_bvalid;
  int checks = 0, errors = 0, mode = 0;
  typedef struct {
    logic [DW-1:0] r;
    logic [BW-1:0] b;
  } exp_t;
  exp_t q[$];

  riscv_v_logic_alu_pipe #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .osize(osize), .srca(srca), .srcb(srcb), .src_bvalid(src_bvalid),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_bvalid(result_bvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: computed element by element from the op definitions
  task automatic model(input logic [3:0] o, input logic [1:0] sz, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [BW-1:0] bv,
                       output logic [DW-1:0] r, output logic [BW-1:0] rb);
    int ew, n, amt;
    logic [63:0] m, ae, v, accum;
    ew = 8 << sz;
    n = DW / ew;
    m = (ew == 64) ? '1 : (64'd1 << ew) - 1;
    r = '0;
    rb = bv;
    if (o <= 2) r = o == 0 ? a & b : o == 1 ? a | b : a ^ b;
    else if (o <= 5) begin
      for (int e = 0; e < n; e++) begin
        ae = 64'(a >> (e * ew)) & m;
        amt = int'((64'(b >> (e * ew)) & m) % 64'(ew));
        v = o == 3 ? (ae << amt) & m : ae >> amt;
        if (o == 5 && ae[ew-1]) v = v | (m & ~(m >> amt));
        r = r | (DW'(v) << (e * ew));
      end
    end else if (o <= 8) begin
      accum = o == 6 ? m : 64'd0;
      for (int e = 0; e < n; e++) begin
        ae = 64'(a >> (e * ew)) & m;
        if (bv[e*ew/8]) accum = o == 6 ? accum & ae : o == 7 ? accum | ae : accum ^ ae;
      end
      ae = 64'(b) & m;
      accum = o == 6 ? accum & ae : o == 7 ? accum | ae : accum ^ ae;
      r = DW'(accum);
      rb = BW'((1 << (ew / 8)) - 1);
    end else begin
      r = '0;
      rb = '0;
    end
  endtask

  task automatic send(input logic [3:0] o, input logic [1:0] sz, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [BW-1:0] bv, output int waited);
    exp_t x;
    @(negedge clk);
    op = o; osize = sz; srca = a; srcb = b; src_bvalid = bv; in_valid = 1;
    model(o, sz, a, b, bv, x.r, x.b);
    waited = 0;
    #2;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #2;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
      in_valid = 0;
    end else begin
      q.push_back(x);
      @(posedge clk);
    end
  endtask

  task automatic wait_out(input int exp_n);
    int n = 0;
    do begin
      @(negedge clk);
      in_valid = 0;
      #2;
      n++;
    end while (!out_valid && n < 50);
    chk("latency", n, exp_n);
  endtask

  // monitor: drives out_ready, pops the scoreboard on each handshake, checks stalls
  initial begin
    logic pv;
    logic [DW-1:0] pr;
    logic [BW-1:0] pb;
    exp_t x;
    pv = 0;
    forever begin
      @(negedge clk);
      out_ready = mode == 0 ? 1'b1 : mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
      #1;
      if (pv) begin
        chk("hold_result", result, pr);
        chk("hold_bvalid", result_bvalid, pb);
        chk("hold_valid", out_valid, 1);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected none", result);
        end else begin
          x = q.pop_front();
          chk("result", result, x.r);
          chk("result_bvalid", result_bvalid, x.b);
        end
      end
      pv = out_valid && !out_ready && !rst;
      pr = result;
      pb = result_bvalid;
    end
  end

  initial begin
    int w, n;
    logic [DW-1:0] a, b;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_bvalid", result_bvalid, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 0;
    mode = 0;
    send(4'd0, 2'd0, {16{8'hF0}}, {16{8'h3C}}, 16'hFFFF, w);
    wait_out(1);
    send(4'd5, 2'd2, {4{32'h8000_0000}}, {4{32'd4}}, 16'hFFFF, w);
    wait_out(1);
    for (int i = 0; i < 16; i++) a[i*8+:8] = 8'(i + 1);
    send(4'd8, 2'd0, a, '0, 16'hFFFF, w);
    wait_out(5);
    a = '0;
    a[15:0] = 16'hFFFF;
    a[31:16] = 16'h0F0F;
    b = '0;
    b[15:0] = 16'hFF00;
    send(4'd6, 2'd1, a, b, 16'h000F, w);
    wait_out(4);
    send(4'd6, 2'd3, {4{32'hDEAD_BEEF}}, '1, 16'h00FF, w);
    wait_out(2);
    send(4'd12, 2'd1, '1, '1, 16'hFFFF, w);
    wait_out(1);
    mode = 2;
    send(4'd3, 2'd0, {4{32'h1234_5678}}, {16{8'h03}}, 16'hFFFF, w);
    fork
      send(4'd4, 2'd1, {4{32'hF00F_8001}}, {8{16'h0005}}, 16'h0F0F, w);
      begin
        repeat (4) @(negedge clk);
        mode = 0;
      end
    join
    chk("stall_wait_ge3", 128'(w >= 3), 1);
    for (int i = 0; i < 3; i++) begin
      send(4'(i), 2'(i), {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), w);
      chk("b2b_wait", w, 0);
    end
    wait_out(1);
    repeat (2) @(negedge clk);
    send(4'd7, 2'd0, {16{8'h5A}}, '0, 16'hFFFF, w);
    @(negedge clk);
    in_valid = 0;
    #2;
    rst = 1;
    #1;
    chk("midfold_rst_valid", out_valid, 0);
    chk("midfold_rst_result", result, 0);
    chk("midfold_rst_bvalid", result_bvalid, 0);
    q.delete();
    @(negedge clk);
    rst = 0;
    send(4'd7, 2'd0, {16'h0100, 112'h0}, 128'h0000_0000_0000_0000_0000_0000_0000_0002, 16'hC001, w);
    wait_out(5);
    mode = 1;
    for (int i = 0; i < 300; i++) begin
      send(4'($urandom_range(0, 11)), 2'($urandom_range(0, 3)),
           {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
           16'($urandom), w);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_valid = 0;
      end
    end
    @(negedge clk);
    in_valid = 0;
    mode = 0;
    n = 0;
    while (q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
